// File: rtl/ysyx_22040750_lsu_stage.sv
// EX->WB load/store stage: holds one instruction and runs a single outstanding
// memory transaction. Optional LSU_MISALIGN_CHECK_EN traps misaligned accesses.
module ysyx_22040750_lsu_stage #(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 32,
    parameter int PAYLOAD_W = 128
) (
    input  logic                  I_sys_clk,
    input  logic                  I_rst_n,
    input  logic                  I_in_valid,
    output logic                  O_allowin,
    input  logic [PAYLOAD_W-1:0]  I_in_payload,
    input  logic                  I_mem_rd,
    input  logic                  I_mem_wr,
    input  logic [1:0]            I_size,
    input  logic                  I_unsigned,
    input  logic [ADDR_W-1:0]     I_addr,
    input  logic [DATA_W-1:0]     I_wdata,
    input  logic                  I_flush,
    output logic                  O_req_valid,
    input  logic                  I_req_ready,
    output logic                  O_req_wr,
    output logic [ADDR_W-1:0]     O_req_addr,
    output logic [DATA_W-1:0]     O_req_wdata,
    output logic [DATA_W/8-1:0]   O_req_wstrb,
    input  logic                  I_rvalid,
    input  logic [DATA_W-1:0]     I_rdata,
    input  logic                  I_bvalid,
    output logic                  O_out_valid,
    input  logic                  I_allowout,
    output logic [PAYLOAD_W-1:0]  O_out_payload,
    output logic [DATA_W-1:0]     O_out_data,
    output logic                  O_misalign,
    output logic                  O_busy
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int SW     = STRB_W + 8;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_RESP, S_DONE, S_DRAIN} state_t;

    state_t                 state_reg;
    logic                   req_valid_reg;
    logic                   req_wr_reg;
    logic [ADDR_W-1:0]      req_addr_reg;
    logic [DATA_W-1:0]      req_wdata_reg;
    logic [STRB_W-1:0]      req_wstrb_reg;
    logic [1:0]             ld_size_reg;
    logic                   ld_unsigned_reg;
    logic [OFF_W-1:0]       ld_off_reg;
    logic                   drain_pending_reg;
    logic                   out_valid_reg;
    logic [PAYLOAD_W-1:0]   out_payload_reg;
    logic [DATA_W-1:0]      out_data_reg;
    logic                   misalign_reg;

    logic                   accept;
    logic                   in_mem;
    logic [OFF_W-1:0]       in_off;
    logic [3:0]             in_bytes;
    logic [SW-1:0]          strb_mask;
    logic [DATA_W-1:0]      wdata_shift;
    logic                   misalign_in;
    logic                   resp_hit;
    logic [DATA_W-1:0]      rsh;
    logic                   sign_bit;
    int                     nbits;
    logic [DATA_W-1:0]      load_ext;

    assign O_allowin = !I_flush && ((state_reg == S_IDLE) ||
                                    ((state_reg == S_DONE) && I_allowout));
    assign accept    = I_in_valid && O_allowin;
    assign in_mem    = I_mem_rd || I_mem_wr;
    assign in_off    = I_addr[OFF_W-1:0];
    assign in_bytes  = 4'd1 << I_size;
    assign strb_mask = ((SW'(1) << in_bytes) - SW'(1)) << in_off;
    assign wdata_shift = I_wdata << {in_off, 3'b000};
    assign resp_hit  = req_wr_reg ? I_bvalid : I_rvalid;

`ifdef LSU_MISALIGN_CHECK_EN
    logic [2:0] align_mask;
    assign align_mask  = 3'(in_bytes - 4'd1);
    assign misalign_in = in_mem && |(I_addr[2:0] & align_mask);
`else
    assign misalign_in = 1'b0;
`endif

    // Lanes above the access are filled with zero or the access's own sign bit.
    always_comb begin
        rsh   = I_rdata >> {ld_off_reg, 3'b000};
        nbits = 8 << ld_size_reg;
        if (nbits > DATA_W) nbits = DATA_W;
        case (ld_size_reg)
            2'd0:    sign_bit = rsh[7];
            2'd1:    sign_bit = rsh[15];
            2'd2:    sign_bit = rsh[31];
            default: sign_bit = rsh[DATA_W-1];
        endcase
        load_ext = '0;
        for (int i = 0; i < DATA_W; i++)
            load_ext[i] = (i < nbits) ? rsh[i] : (!ld_unsigned_reg && sign_bit);
    end

    always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_reg         <= S_IDLE;
            req_valid_reg     <= 1'b0;
            req_wr_reg        <= 1'b0;
            req_addr_reg      <= '0;
            req_wdata_reg     <= '0;
            req_wstrb_reg     <= '0;
            ld_size_reg       <= '0;
            ld_unsigned_reg   <= 1'b0;
            ld_off_reg        <= '0;
            drain_pending_reg <= 1'b0;
            out_valid_reg     <= 1'b0;
            out_payload_reg   <= '0;
            out_data_reg      <= '0;
            misalign_reg      <= 1'b0;
        end else if (accept) begin
            // Only reachable from IDLE or a completing DONE, so one path serves both.
            out_payload_reg   <= I_in_payload;
            out_data_reg      <= DATA_W'(I_addr);
            req_addr_reg      <= I_addr;
            req_wr_reg        <= I_mem_wr;
            req_wdata_reg     <= wdata_shift;
            req_wstrb_reg     <= I_mem_wr ? strb_mask[STRB_W-1:0] : '0;
            ld_size_reg       <= I_size;
            ld_unsigned_reg   <= I_unsigned;
            ld_off_reg        <= in_off;
            drain_pending_reg <= 1'b0;
            if (in_mem && !misalign_in) begin
                state_reg     <= S_REQ;
                req_valid_reg <= 1'b1;
                out_valid_reg <= 1'b0;
                misalign_reg  <= 1'b0;
            end else begin
                state_reg     <= S_DONE;
                out_valid_reg <= 1'b1;
                misalign_reg  <= misalign_in;
            end
        end else begin
            case (state_reg)
                S_REQ: begin
                    if (I_req_ready) begin
                        req_valid_reg     <= 1'b0;
                        drain_pending_reg <= 1'b0;
                        state_reg         <= I_flush ? S_DRAIN : S_RESP;
                    end else if (I_flush) begin
                        drain_pending_reg <= 1'b1;
                        state_reg         <= S_DRAIN;
                    end
                end
                S_RESP: begin
                    if (resp_hit) begin
                        if (I_flush) begin
                            state_reg <= S_IDLE;
                        end else begin
                            state_reg     <= S_DONE;
                            out_valid_reg <= 1'b1;
                            if (!req_wr_reg) out_data_reg <= load_ext;
                        end
                    end else if (I_flush) begin
                        state_reg <= S_DRAIN;
                    end
                end
                S_DONE: begin
                    if (I_flush || I_allowout) begin
                        state_reg     <= S_IDLE;
                        out_valid_reg <= 1'b0;
                        misalign_reg  <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    // Finish the bus handshake, then swallow the response.
                    if (drain_pending_reg) begin
                        if (I_req_ready) begin
                            drain_pending_reg <= 1'b0;
                            req_valid_reg     <= 1'b0;
                        end
                    end else if (resp_hit) begin
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign O_req_valid   = req_valid_reg;
    assign O_req_wr      = req_wr_reg;
    assign O_req_addr    = req_addr_reg;
    assign O_req_wdata   = req_wdata_reg;
    assign O_req_wstrb   = req_wstrb_reg;
    assign O_out_valid   = out_valid_reg;
    assign O_out_payload = out_payload_reg;
    assign O_out_data    = out_data_reg;
    assign O_misalign    = misalign_reg;
    assign O_busy        = (state_reg != S_IDLE);

endmodule

// File: tb/tb_ysyx_22040750_lsu_stage.sv
// Randomized self-checking bench for ysyx_22040750_lsu_stage (DATA_W=64).
module tb_ysyx_22040750_lsu_stage;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         allowin;
    logic [127:0] in_payload = '0;
    logic         mem_rd = 1'b0, mem_wr = 1'b0;
    logic [1:0]   size = '0;
    logic         uns = 1'b0;
    logic [31:0]  addr = '0;
    logic [63:0]  wdata = '0;
    logic         flush = 1'b0;
    logic         req_valid, req_wr;
    logic         req_ready = 1'b0;
    logic [31:0]  req_addr;
    logic [63:0]  req_wdata;
    logic [7:0]   req_wstrb;
    logic         rvalid = 1'b0, bvalid = 1'b0;
    logic [63:0]  rdata = '0;
    logic         out_valid;
    logic         allowout = 1'b0;
    logic [127:0] out_payload;
    logic [63:0]  out_data;
    logic         misalign, busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ysyx_22040750_lsu_stage dut (
        .I_sys_clk(clk), .I_rst_n(rst_n), .I_in_valid(in_valid), .O_allowin(allowin),
        .I_in_payload(in_payload), .I_mem_rd(mem_rd), .I_mem_wr(mem_wr), .I_size(size),
        .I_unsigned(uns), .I_addr(addr), .I_wdata(wdata), .I_flush(flush),
        .O_req_valid(req_valid), .I_req_ready(req_ready), .O_req_wr(req_wr),
        .O_req_addr(req_addr), .O_req_wdata(req_wdata), .O_req_wstrb(req_wstrb),
        .I_rvalid(rvalid), .I_rdata(rdata), .I_bvalid(bvalid), .O_out_valid(out_valid),
        .I_allowout(allowout), .O_out_payload(out_payload), .O_out_data(out_data),
        .O_misalign(misalign), .O_busy(busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: byte k of the access lives in bus lane off+k; lanes past the bus are lost.
    function automatic logic [7:0] model_strb(bit wr, int sz, int off);
        logic [7:0] s = '0;
        for (int b = 0; b < 8; b++)
            if (wr && b >= off && b < off + (1 << sz)) s[b] = 1'b1;
        return s;
    endfunction

    function automatic logic [63:0] model_load(logic [63:0] rd, int sz, bit u, int off);
        logic [63:0] v = '0;
        int nb = 1 << sz;
        for (int k = 0; k < nb; k++)
            if (off + k < 8) v[8*k +: 8] = rd[8*(off+k) +: 8];
        if (!u && nb < 8 && v[8*nb-1])
            for (int b = 8 * nb; b < 64; b++) v[b] = 1'b1;
        return v;
    endfunction

    task automatic present(bit rd, bit wr, logic [1:0] sz, bit u, logic [31:0] a,
                           logic [63:0] wd, logic [127:0] pl);
        in_valid = 1'b1; mem_rd = rd; mem_wr = wr; size = sz; uns = u;
        addr = a; wdata = wd; in_payload = pl;
    endtask

    task automatic release_in;
        in_valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests++; if (req_valid !== 1'b0) begin fails++; $display("FAIL reset_req_valid got %b want 0", req_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (out_data !== 64'h0 || out_payload !== 128'h0) begin fails++; $display("FAIL reset_data got %h/%h want 0", out_data, out_payload); end
        tests++; if (misalign !== 1'b0 || req_wstrb !== 8'h0) begin fails++; $display("FAIL reset_misalign_strb got %b/%h want 0", misalign, req_wstrb); end
        tests++; if (allowin !== 1'b1) begin fails++; $display("FAIL reset_allowin got %b want 1", allowin); end
    endtask

    task automatic test_nonmem;
        allowout = 1'b1;
        present(0, 0, 2'd0, 0, 32'h8000_0010, 64'h0, 128'hABC);
        tick();
        release_in();
        $display("[TB] nonmem addr=%h", 32'h8000_0010);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL nonmem_valid got %b want 1", out_valid); end
        tests++; if (out_data !== 64'h8000_0010) begin fails++; $display("FAIL nonmem_data got %h want %h", out_data, 64'h8000_0010); end
        tests++; if (out_payload !== 128'hABC) begin fails++; $display("FAIL nonmem_payload got %h want abc", out_payload); end
        tests++; if (req_valid !== 1'b0) begin fails++; $display("FAIL nonmem_no_req got %b want 0", req_valid); end
        tick();
        allowout = 1'b0;
        tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL nonmem_retire got %b/%b want 0/0", out_valid, busy); end
    endtask

    task automatic run_mem_op(bit wr, logic [1:0] sz, bit u, logic [31:0] a, logic [63:0] wd,
                              logic [63:0] rd, int rdy_dly, int rsp_dly, logic [127:0] pl);
        int off = int'(a[2:0]);
        logic [7:0]  e_strb = model_strb(wr, int'(sz), off);
        logic [63:0] e_wd = wd << (8 * off);
        logic [63:0] e_out = wr ? {32'h0, a} : model_load(rd, int'(sz), u, off);
        bit mis = (a % (32'd1 << sz)) != 0;
        $display("[TB] mem wr=%0d size=%0d uns=%0d addr=%h rdy=%0d rsp=%0d", wr, sz, u, a, rdy_dly, rsp_dly);
        present(!wr, wr, sz, u, a, wd, pl);
        #1;
        tests++; if (allowin !== 1'b1) begin fails++; $display("FAIL mem_allowin got %b want 1", allowin); end
        tick();
        release_in();
`ifdef LSU_MISALIGN_CHECK_EN
        if (mis) begin
            tests++; if (req_valid !== 1'b0 || out_valid !== 1'b1 || misalign !== 1'b1) begin fails++; $display("FAIL misalign_trap got req=%b out=%b mis=%b want 0/1/1", req_valid, out_valid, misalign); end
            tests++; if (out_data !== {32'h0, a}) begin fails++; $display("FAIL misalign_addr got %h want %h", out_data, a); end
            allowout = 1'b1; tick(); allowout = 1'b0;
            return;
        end
`else
        if (mis) begin
            tests++; if (misalign !== 1'b0) begin fails++; $display("FAIL misalign_tied got %b want 0", misalign); end
        end
`endif
        tests++; if (req_valid !== 1'b1 || req_wr !== wr || req_addr !== a) begin fails++; $display("FAIL req_issue got v=%b wr=%b a=%h want 1/%b/%h", req_valid, req_wr, req_addr, wr, a); end
        tests++; if (req_wstrb !== e_strb) begin fails++; $display("FAIL req_wstrb got %h want %h", req_wstrb, e_strb); end
        if (wr) begin
            tests++; if (req_wdata !== e_wd) begin fails++; $display("FAIL req_wdata got %h want %h", req_wdata, e_wd); end
        end
        for (int i = 0; i < rdy_dly; i++) begin
            tick();
            tests++; if (req_valid !== 1'b1 || req_addr !== a || req_wstrb !== e_strb || (wr && req_wdata !== e_wd)) begin fails++; $display("FAIL req_hold cycle %0d got v=%b a=%h s=%h d=%h want 1/%h/%h/%h", i, req_valid, req_addr, req_wstrb, req_wdata, a, e_strb, e_wd); end
        end
        req_ready = 1'b1; tick(); req_ready = 1'b0;
        tests++; if (req_valid !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL resp_wait got req=%b out=%b want 0/0", req_valid, out_valid); end
        for (int i = 0; i < rsp_dly; i++) begin
            tick();
            tests++; if (out_valid !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL resp_idle got out=%b busy=%b want 0/1", out_valid, busy); end
        end
        if (wr) bvalid = 1'b1; else begin rvalid = 1'b1; rdata = rd; end
        tick();
        bvalid = 1'b0; rvalid = 1'b0;
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL out_valid got %b want 1", out_valid); end
        tests++; if (out_data !== e_out) begin fails++; $display("FAIL out_data got %h want %h", out_data, e_out); end
        tests++; if (out_payload !== pl) begin fails++; $display("FAIL out_payload got %h want %h", out_payload, pl); end
        allowout = 1'b1; tick(); allowout = 1'b0;
        tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL mem_retire got %b/%b want 0/0", out_valid, busy); end
    endtask

    task automatic test_directed_mem;
        run_mem_op(0, 2'd0, 0, 32'h8000_0003, 64'h0, 64'h0000_0000_FF00_0000, 0, 0, 128'h11);
        run_mem_op(0, 2'd0, 1, 32'h8000_0003, 64'h0, 64'h0000_0000_FF00_0000, 0, 0, 128'h12);
        run_mem_op(1, 2'd1, 0, 32'h8000_0006, 64'h1234, 64'h0, 4, 1, 128'h13);
        run_mem_op(0, 2'd2, 0, 32'h8000_0002, 64'h0, 64'h0000_8765_4321_0000, 0, 0, 128'h14);
        run_mem_op(1, 2'd2, 0, 32'h8000_0006, 64'hDEAD_BEEF, 64'h0, 1, 0, 128'h15);
    endtask

    task automatic test_flush;
        // Flush during RESP: response is consumed, nothing reaches WB.
        present(1, 0, 2'd2, 0, 32'h8000_0008, 64'h0, 128'h21);
        tick(); release_in();
        req_ready = 1'b1; tick(); req_ready = 1'b0;
        flush = 1'b1; #1;
        tests++; if (allowin !== 1'b0) begin fails++; $display("FAIL flush_allowin_low got %b want 0", allowin); end
        tick(); flush = 1'b0;
        $display("[TB] flush in RESP");
        tests++; if (busy !== 1'b1 || req_valid !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL flush_drain got b=%b r=%b o=%b want 1/0/0", busy, req_valid, out_valid); end
        rvalid = 1'b1; rdata = 64'hFFFF; tick(); rvalid = 1'b0;
        tests++; if (busy !== 1'b0 || out_valid !== 1'b0 || allowin !== 1'b1) begin fails++; $display("FAIL flush_done got b=%b o=%b a=%b want 0/0/1", busy, out_valid, allowin); end
        // Flush during REQ: request must stay up until accepted.
        present(0, 1, 2'd3, 0, 32'h8000_0010, 64'h5, 128'h22);
        tick(); release_in();
        flush = 1'b1; tick(); flush = 1'b0;
        $display("[TB] flush in REQ");
        tests++; if (req_valid !== 1'b1) begin fails++; $display("FAIL flush_req_held got %b want 1", req_valid); end
        tick();
        tests++; if (req_valid !== 1'b1 || req_wstrb !== 8'hFF) begin fails++; $display("FAIL flush_req_held2 got %b/%h want 1/ff", req_valid, req_wstrb); end
        req_ready = 1'b1; tick(); req_ready = 1'b0;
        tests++; if (req_valid !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL flush_req_taken got %b/%b want 0/1", req_valid, busy); end
        bvalid = 1'b1; tick(); bvalid = 1'b0;
        tests++; if (busy !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL flush_req_end got %b/%b want 0/0", busy, out_valid); end
        // Flush in DONE drops the result.
        present(0, 0, 2'd0, 0, 32'h0000_0044, 64'h0, 128'h23);
        tick(); release_in();
        flush = 1'b1; tick(); flush = 1'b0;
        $display("[TB] flush in DONE");
        tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL flush_done_drop got %b/%b want 0/0", out_valid, busy); end
        // Flush beats a simultaneous valid input.
        present(0, 0, 2'd0, 0, 32'h0000_0048, 64'h0, 128'h24);
        flush = 1'b1; #1;
        tests++; if (allowin !== 1'b0) begin fails++; $display("FAIL flush_beats_valid got %b want 0", allowin); end
        tick(); flush = 1'b0; release_in();
        tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL flush_no_accept got %b/%b want 0/0", out_valid, busy); end
    endtask

    task automatic test_back_to_back;
        present(0, 0, 2'd0, 0, 32'h1000_0000, 64'h0, 128'h31);
        tick(); release_in();
        $display("[TB] stall then back-to-back");
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++; if (out_valid !== 1'b1 || out_data !== 64'h1000_0000 || allowin !== 1'b0) begin fails++; $display("FAIL stall cycle %0d got v=%b d=%h a=%b want 1/10000000/0", i, out_valid, out_data, allowin); end
        end
        allowout = 1'b1;
        present(0, 0, 2'd0, 0, 32'h2000_0000, 64'h0, 128'h32);
        #1;
        tests++; if (allowin !== 1'b1) begin fails++; $display("FAIL b2b_allowin got %b want 1", allowin); end
        tick(); release_in(); allowout = 1'b0;
        tests++; if (out_valid !== 1'b1 || out_data !== 64'h2000_0000 || out_payload !== 128'h32) begin fails++; $display("FAIL b2b_out got v=%b d=%h p=%h want 1/20000000/32", out_valid, out_data, out_payload); end
        allowout = 1'b1; tick(); allowout = 1'b0;
        // Stray responses while idle are ignored.
        rvalid = 1'b1; bvalid = 1'b1; tick(); rvalid = 1'b0; bvalid = 1'b0;
        tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL stray_resp got %b/%b want 0/0", out_valid, busy); end
    endtask

    task automatic test_async_reset;
        present(1, 0, 2'd3, 0, 32'h8000_0020, 64'h0, 128'h41);
        tick(); release_in();
        tests++; if (req_valid !== 1'b1) begin fails++; $display("FAIL areset_pre got %b want 1", req_valid); end
        #2 rst_n = 1'b0; #1;
        $display("[TB] async reset mid-request");
        tests++; if (req_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL areset_drop got %b/%b want 0/0", req_valid, busy); end
        tick(); rst_n = 1'b1; tick();
    endtask

    task automatic test_random;
        for (int n = 0; n < 40; n++) begin
            bit          wr  = 1'($urandom_range(0, 1));
            logic [1:0]  sz  = 2'($urandom_range(0, 3));
            bit          u   = 1'($urandom_range(0, 1));
            logic [31:0] a   = 32'h8000_0000 | 32'($urandom_range(0, 255));
            logic [63:0] wd  = {$urandom, $urandom};
            logic [63:0] rd  = {$urandom, $urandom};
            logic [127:0] pl = {$urandom, $urandom, $urandom, $urandom};
            run_mem_op(wr, sz, u, a, wd, rd, $urandom_range(0, 3), $urandom_range(0, 3), pl);
        end
    endtask

    initial begin
        test_reset();
        test_nonmem();
        test_directed_mem();
        test_flush();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ysyx_22040750_lsu_stage.md
Name: ysyx_22040750_lsu_stage

Overview:
Parametrised successor to the EX/MEM pipeline register. Holds one instruction between EX and WB and runs a single-outstanding load/store transaction on a valid/ready request channel. Generates byte strobes and lane-shifted write data, aligns and sign/zero-extends load data, and supports pipeline flush with safe drain of in-flight transactions. Data width, address width and sideband payload width are parameters.

Parameters:
DATA_W, 64, memory data bus width in bits (32 or 64)
ADDR_W, 32, memory address width
PAYLOAD_W, 128, opaque sideband bits passed EX->WB (pc, rd, wen, csr fields, debug)

Ports:
I_sys_clk  in  1  clock
I_rst_n  in  1  asynchronous active-low reset
I_in_valid  in  1  EX presents an instruction
O_allowin  out  1  stage accepts this cycle
I_in_payload  in  PAYLOAD_W  sideband captured on accept
I_mem_rd / I_mem_wr  in  1 each  load / store (mutually exclusive)
I_size  in  2  access size: 0=1B 1=2B 2=4B 3=8B (3 illegal when DATA_W=32)
I_unsigned  in  1  zero-extend load
I_addr  in  ADDR_W  byte address (alu result)
I_wdata  in  DATA_W  store data, LSB-aligned
I_flush  in  1  kill held/incoming instruction
O_req_valid  out  1  memory request valid
I_req_ready  in  1  memory accepts request
O_req_wr  out  1  1=write, 0=read
O_req_addr  out  ADDR_W  request address (unmodified I_addr)
O_req_wdata  out  DATA_W  I_wdata shifted left by 8*addr[lane bits]
O_req_wstrb  out  DATA_W/8  ((1<<bytes)-1) shifted by lane offset; 0 for reads
I_rvalid  in  1  read data valid
I_rdata  in  DATA_W  read data
I_bvalid  in  1  write response valid
O_out_valid  out  1  result valid to WB
I_allowout  in  1  WB accepts
O_out_payload  out  PAYLOAD_W  captured sideband
O_out_data  out  DATA_W  load result (extended) or alu address for non-load ops
O_misalign  out  1  misaligned-access flag (see Optional Feature)
O_busy  out  1  state != IDLE

Behaviour:
- States: IDLE, REQ, RESP, DONE, DRAIN. Reset -> IDLE; all outputs and data registers 0.
- O_allowin = !I_flush && (IDLE || (DONE && I_allowout)). Accept = I_in_valid && O_allowin.
- Accept, non-mem op -> DONE next cycle; O_out_data = I_addr zero-extended.
- Accept, mem op -> REQ; O_req_valid=1 from next cycle, held with stable addr/wdata/wstrb/wr until I_req_ready.
- REQ && I_req_ready -> RESP. Responses never arrive in the handshake cycle; I_rvalid/I_bvalid outside RESP/DRAIN ignored.
- RESP && I_rvalid (read) -> DONE; data = I_rdata >> 8*offset, truncated to size, sign- or zero-extended to DATA_W, registered. RESP && I_bvalid (write) -> DONE. O_out_valid rises the cycle after the response.
- DONE: O_out_valid=1 until I_allowout; on handshake without new accept -> IDLE; with accept -> back-to-back per above.
- Flush: IDLE/DONE -> IDLE, output dropped, O_out_valid low next cycle. REQ/RESP -> DRAIN: request held until ready, response awaited, then IDLE with no output. I_flush beats I_in_valid in the same cycle.
- Minimum latency: non-mem 1 cycle accept->out_valid; load with ready immediate and response next cycle: 3 cycles.
- Lane offset = addr[log2(DATA_W/8)-1:0]. Accesses crossing lane boundary: strobe/data bits beyond bus truncated.
- Reset mid-transaction: immediate IDLE, O_req_valid drops asynchronously; memory side must also be reset.

Optional Feature:
LSU_MISALIGN_CHECK_EN defined: mem op with addr not a multiple of size skips REQ, goes straight to DONE with O_misalign=1 and O_out_data = faulting address; flush rules as DONE. Undefined: O_misalign tied 0; misaligned accesses issued with truncation as above.

Test Plan:
- Non-mem op, payload 0xABC, addr 0x80000010, I_allowout=1 -> O_out_valid at cycle+1, O_out_data=0x80000010, payload 0xABC.
- lb addr 0x80000003, rdata 0x00000000_FF000000 (DATA_W=64), ready immediate, rvalid next cycle -> O_out_data=0xFFFFFFFF_FFFFFFFF; lbu same -> 0xFF; O_out_valid 3 cycles after accept.
- sh addr 0x80000006, wdata 0x1234 -> O_req_wstrb=0xC0, O_req_wdata=0x1234_0000_0000_0000, held 4 cycles while I_req_ready=0; out_valid after bvalid.
- I_flush while in RESP for lw -> O_req_valid unaffected, state DRAIN, rvalid consumed, no O_out_valid; O_allowin high next cycle.
- DONE with I_allowout=0 for 5 cycles -> O_out_valid and data stable, O_allowin=0; then allowout=1 with new input -> back-to-back accept.
- LSU_MISALIGN_CHECK_EN: lw addr 0x80000002 -> no O_req_valid, O_misalign=1, O_out_data=0x80000002; without macro request issued, wstrb/data truncated.
